// File: rtl/ceespu_gpu_pkg.sv
// ceespu_gpu_pkg
// Constants and types shared by the text-mode GPU blocks (blit engine and
// pixel side).
//   COLS, ROWS : character grid size
//   W, T       : 32-bit words per row / words per screen (4 chars per word)
//   OP_*       : blit command encodings
//   blit_state_e : blit engine sequencing states
package ceespu_gpu_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int W    = COLS / 4;
  localparam int T    = W * ROWS;

  localparam logic OP_FILL   = 1'b0;
  localparam logic OP_SCROLL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,    // read both RAMs at src
    ST_CAP,   // capture read data into the hold registers
    ST_WR,    // write held data at dst
    ST_FILL,  // write fill pattern at dst
    ST_DONE
  } blit_state_e;

  // Replicate one character/colour byte across a 32-bit RAM word.
  function automatic logic [31:0] fill_word(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/ceespu_gpu_port_mux.sv
// ceespu_gpu_port_mux
// Combinational CPU-vs-engine select for one RAM port A.
//   cpu_hit          : CPU is writing this RAM in this cycle
//   cpu_any          : CPU is writing either RAM; the engine drives both
//                      RAMs in lockstep, so any CPU access blocks it
//   cpu_we/addr/data : CPU request fields
//   eng_en/we/addr/din : engine request fields
//   en/we/addr/din   : port A outputs
//   stall            : engine wanted this port but the CPU owns it
module ceespu_gpu_port_mux #(
  parameter int AW = 10
) (
  input  logic          cpu_hit,
  input  logic          cpu_any,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_data,
  input  logic          eng_en,
  input  logic [3:0]    eng_we,
  input  logic [AW-1:0] eng_addr,
  input  logic [31:0]   eng_din,
  output logic          en,
  output logic [3:0]    we,
  output logic [AW-1:0] addr,
  output logic [31:0]   din,
  output logic          stall
);

  always_comb begin
    en   = 1'b0;
    we   = 4'h0;
    addr = '0;
    din  = '0;
    if (cpu_hit) begin
      en   = 1'b1;
      we   = cpu_we;
      addr = cpu_addr;
      din  = cpu_data;
    end else if (eng_en && !cpu_any) begin
      en   = 1'b1;
      we   = eng_we;
      addr = eng_addr;
      din  = eng_din;
    end
  end

  assign stall = eng_en && cpu_hit;

endmodule

// File: rtl/ceespu_gpu_blit_ctrl.sv
// ceespu_gpu_blit_ctrl
// Fill / scroll-up engine owning port A of the text and colour RAMs.
// CPU byte writes have priority; an engine port cycle that collides with
// one simply stalls.
//   I_sys_clk, I_sys_rst_n : clock, synchronous active-low reset
//   I_cpu_*                : CPU write request (we, sel, addr, data)
//   I_cmd_* / O_cmd_ready  : command handshake (op, rows, char, colour)
//   O_text_*, O_colour_*   : RAM port A (en, we, addr, din)
//   I_text_dout, I_colour_dout : RAM read data, one cycle after a read
//   O_busy, O_done         : command in progress / completion pulse
module ceespu_gpu_blit_ctrl
  import ceespu_gpu_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 10
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rst_n,
  input  logic [3:0]    I_cpu_we,
  input  logic          I_cpu_sel,
  input  logic [AW-1:0] I_cpu_addr,
  input  logic [31:0]   I_cpu_data,
  input  logic          I_cmd_valid,
  output logic          O_cmd_ready,
  input  logic          I_cmd_op,
  input  logic [4:0]    I_cmd_rows,
  input  logic [7:0]    I_cmd_char,
  input  logic [7:0]    I_cmd_colour,
  output logic          O_text_en,
  output logic          O_colour_en,
  output logic [3:0]    O_text_we,
  output logic [3:0]    O_colour_we,
  output logic [AW-1:0] O_text_addr,
  output logic [AW-1:0] O_colour_addr,
  output logic [31:0]   O_text_din,
  output logic [31:0]   O_colour_din,
  input  logic [31:0]   I_text_dout,
  input  logic [31:0]   I_colour_dout,
  output logic          O_busy,
  output logic          O_done
);

  localparam int WPR = COLS / 4;
  localparam int TOT = WPR * ROWS;
  localparam logic [AW-1:0] LAST  = AW'(TOT - 1);
  localparam logic [AW-1:0] TOT_A = AW'(TOT);

  blit_state_e   state, state_nxt;
  logic [AW-1:0] dst, src, wn;
  logic [7:0]    fill_char, fill_col;
  logic [31:0]   hold_t, hold_c;

  logic          accept, stall, stall_t, stall_c, cpu_any;
  int            rows_i;
  logic [AW-1:0] wn_calc, copy_last;

  logic          eng_en;
  logic [3:0]    eng_we;
  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_din_t, eng_din_c;

  assign cpu_any   = |I_cpu_we;
  assign accept    = I_cmd_valid && (state == ST_IDLE);
  assign rows_i    = int'(I_cmd_rows);
  assign wn_calc   = AW'(WPR * rows_i);
  // Last destination of the copy phase; the fill phase starts right after.
  assign copy_last = TOT_A - wn - AW'(1);
  assign stall     = stall_t || stall_c;

  // ---------------- state register ----------------
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (I_cmd_op == OP_FILL || rows_i >= ROWS) state_nxt = ST_FILL;
          else if (rows_i == 0)                      state_nxt = ST_DONE;
          else                                       state_nxt = ST_RD;
        end
      end
      ST_RD:   if (!stall) state_nxt = ST_CAP;
      ST_CAP:  state_nxt = ST_WR;
      ST_WR:   if (!stall) state_nxt = (dst == copy_last) ? ST_FILL : ST_RD;
      ST_FILL: if (!stall && dst == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- counters and hold registers ----------------
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) begin
      dst       <= '0;
      src       <= '0;
      wn        <= '0;
      fill_char <= '0;
      fill_col  <= '0;
      hold_t    <= '0;
      hold_c    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fill_char <= I_cmd_char;
            fill_col  <= I_cmd_colour;
            wn        <= wn_calc;
            dst       <= '0;
            src       <= wn_calc;
          end
        end
        ST_CAP: begin
          hold_t <= I_text_dout;
          hold_c <= I_colour_dout;
        end
        ST_WR: begin
          if (!stall) begin
            dst <= dst + AW'(1);
            src <= src + AW'(1);
          end
        end
        ST_FILL: begin
          if (!stall && dst != LAST) dst <= dst + AW'(1);
        end
        ST_DONE: begin
          dst <= '0;
          src <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- engine port request ----------------
  always_comb begin
    eng_en    = 1'b0;
    eng_we    = 4'h0;
    eng_addr  = dst;
    eng_din_t = hold_t;
    eng_din_c = hold_c;
    case (state)
      ST_RD: begin
        eng_en   = 1'b1;
        eng_addr = src;
      end
      ST_WR: begin
        eng_en = 1'b1;
        eng_we = 4'hF;
      end
      ST_FILL: begin
        eng_en    = 1'b1;
        eng_we    = 4'hF;
        eng_din_t = fill_word(fill_char);
        eng_din_c = fill_word(fill_col);
      end
      default: ;
    endcase
  end

  ceespu_gpu_port_mux #(.AW(AW)) u_text_mux (
    .cpu_hit  (cpu_any && !I_cpu_sel),
    .cpu_any  (cpu_any),
    .cpu_we   (I_cpu_we),
    .cpu_addr (I_cpu_addr),
    .cpu_data (I_cpu_data),
    .eng_en   (eng_en),
    .eng_we   (eng_we),
    .eng_addr (eng_addr),
    .eng_din  (eng_din_t),
    .en       (O_text_en),
    .we       (O_text_we),
    .addr     (O_text_addr),
    .din      (O_text_din),
    .stall    (stall_t)
  );

  ceespu_gpu_port_mux #(.AW(AW)) u_colour_mux (
    .cpu_hit  (cpu_any && I_cpu_sel),
    .cpu_any  (cpu_any),
    .cpu_we   (I_cpu_we),
    .cpu_addr (I_cpu_addr),
    .cpu_data (I_cpu_data),
    .eng_en   (eng_en),
    .eng_we   (eng_we),
    .eng_addr (eng_addr),
    .eng_din  (eng_din_c),
    .en       (O_colour_en),
    .we       (O_colour_we),
    .addr     (O_colour_addr),
    .din      (O_colour_din),
    .stall    (stall_c)
  );

  assign O_cmd_ready = (state == ST_IDLE);
  assign O_busy      = (state != ST_IDLE);
  assign O_done      = (state == ST_DONE);

endmodule

// File: tb/tb_ceespu_gpu_blit_ctrl.sv
module tb_ceespu_gpu_blit_ctrl;
  import ceespu_gpu_pkg::*;

  localparam int AW = 10;
  localparam int MW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    cpu_we = '0;
  logic          cpu_sel = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_data = '0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [4:0]    cmd_rows = '0;
  logic [7:0]    cmd_char = '0, cmd_colour = '0;
  logic          t_en, c_en, busy, done;
  logic [3:0]    t_we, c_we;
  logic [AW-1:0] t_addr, c_addr;
  logic [31:0]   t_din, c_din;
  logic [31:0]   tdout = '0, cdout = '0;

  ceespu_gpu_blit_ctrl #(.COLS(80), .ROWS(30), .AW(AW)) dut (
    .I_sys_clk(clk), .I_sys_rst_n(rst_n),
    .I_cpu_we(cpu_we), .I_cpu_sel(cpu_sel), .I_cpu_addr(cpu_addr), .I_cpu_data(cpu_data),
    .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready), .I_cmd_op(cmd_op),
    .I_cmd_rows(cmd_rows), .I_cmd_char(cmd_char), .I_cmd_colour(cmd_colour),
    .O_text_en(t_en), .O_colour_en(c_en), .O_text_we(t_we), .O_colour_we(c_we),
    .O_text_addr(t_addr), .O_colour_addr(c_addr), .O_text_din(t_din), .O_colour_din(c_din),
    .I_text_dout(tdout), .I_colour_dout(cdout), .O_busy(busy), .O_done(done)
  );

  // RAM models, write trace and accept counter
  logic [31:0] tmem [0:MW-1];
  logic [31:0] cmem [0:MW-1];
  logic [31:0] old_t [0:MW-1];
  logic [31:0] old_c [0:MW-1];
  logic [AW+31:0] trace [$];
  logic [AW+31:0] fill_trace [$];
  int wr_cnt, max_addr, acc_cnt;
  int checks = 0, fails = 0;

  always @(posedge clk) begin
    if (t_en) begin
      if (t_we == 4'h0) tdout <= tmem[t_addr];
      else begin
        for (int b = 0; b < 4; b++)
          if (t_we[b]) tmem[t_addr][8*b +: 8] = t_din[8*b +: 8];
        wr_cnt++;
        if (int'(t_addr) > max_addr) max_addr = int'(t_addr);
        trace.push_back({t_addr, t_din});
      end
    end
    if (c_en) begin
      if (c_we == 4'h0) cdout <= cmem[c_addr];
      else
        for (int b = 0; b < 4; b++)
          if (c_we[b]) cmem[c_addr][8*b +: 8] = c_din[8*b +: 8];
    end
    if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic int exp_cycles(input logic op, input int n);
    if (op == OP_FILL || n >= ROWS) return T + 1;
    if (n == 0) return 1;
    return 3 * (T - W * n) + W * n + 1;
  endfunction

  function automatic logic [31:0] exp_word(input bit is_col, input int k, input logic op,
                                           input int n, input logic [7:0] fb);
    logic [31:0] o;
    o = is_col ? old_c[k] : old_t[k];
    if (k >= T) return o;
    if (op == OP_SCROLL && n == 0) return o;
    if (op == OP_SCROLL && n < ROWS && k + W * n < T)
      return is_col ? old_c[k + W * n] : old_t[k + W * n];
    return {fb, fb, fb, fb};
  endfunction

  task automatic preload(input bit seq);
    for (int k = 0; k < MW; k++) begin
      tmem[k] = seq ? 32'(k) : $urandom;
      cmem[k] = $urandom;
    end
  endtask

  task automatic start_cmd(input logic op, input int n, input logic [7:0] ch, input logic [7:0] col);
    @(negedge clk);
    for (int k = 0; k < MW; k++) begin
      old_t[k] = tmem[k];
      old_c[k] = cmem[k];
    end
    wr_cnt = 0; max_addr = -1; trace.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_rows = 5'(n); cmd_char = ch; cmd_colour = col;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts cycles after accept until O_done is seen; also checks the pulse width.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    forever begin
      @(negedge clk);
      c++;
      if (done) break;
      if (c > 5000) break;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: no O_done after %0d cycles", c);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: done=%0b ready=%0b, required done=0 ready=1", done, cmd_ready);
    end
  endtask

  task automatic check_mem(input string name, input logic op, input int n,
                           input logic [7:0] ch, input logic [7:0] col);
    int bad = 0;
    int first = -1;
    for (int k = 0; k < MW; k++) begin
      if (tmem[k] !== exp_word(1'b0, k, op, n, ch) || cmem[k] !== exp_word(1'b1, k, op, n, col)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_mem: %0d wrong words (first at %0d: text %h colour %h), required 0",
               name, bad, first, tmem[first], cmem[first]);
    end
  endtask

  task automatic run_case(input string name, input bit seq, input logic op, input int n,
                          input logic [7:0] ch, input logic [7:0] col);
    int cyc, exp_w;
    preload(seq);
    start_cmd(op, n, ch, col);
    wait_done(0, cyc);
    checks++;
    if (cyc != exp_cycles(op, n)) begin
      fails++;
      $display("FAIL %s_cycles: got %0d required %0d", name, cyc, exp_cycles(op, n));
    end
    exp_w = (op == OP_SCROLL && n == 0) ? 0 : T;
    checks++;
    if (wr_cnt != exp_w) begin
      fails++;
      $display("FAIL %s_writes: got %0d required %0d", name, wr_cnt, exp_w);
    end
    checks++;
    if (max_addr > T - 1) begin
      fails++;
      $display("FAIL %s_maxaddr: got %0d required <= %0d", name, max_addr, T - 1);
    end
    check_mem(name, op, n, ch, col);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || t_en !== 1'b0 || c_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%0b busy=%0b done=%0b ten=%0b cen=%0b, required 1 0 0 0 0",
               cmd_ready, busy, done, t_en, c_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    run_case("fill", 1'b0, OP_FILL, 0, 8'h41, 8'h1F);
    fill_trace = trace;
  endtask

  task automatic test_scroll1;
    run_case("scroll1", 1'b1, OP_SCROLL, 1, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_scroll_rand;
    for (int i = 0; i < 3; i++)
      run_case("scroll_rand", 1'b0, OP_SCROLL, int'($urandom_range(2, 29)),
               8'($urandom), 8'($urandom));
    run_case("scroll29", 1'b0, OP_SCROLL, 29, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_scroll_edges;
    bit same;
    run_case("scroll0", 1'b0, OP_SCROLL, 0, 8'h55, 8'h66);
    run_case("scroll30", 1'b0, OP_SCROLL, 30, 8'h12, 8'h34);
    run_case("scroll31", 1'b0, OP_SCROLL, 31, 8'h41, 8'h1F);
    same = (trace.size() == fill_trace.size());
    if (same)
      for (int i = 0; i < trace.size(); i++)
        if (trace[i] !== fill_trace[i]) same = 0;
    checks++;
    if (!same) begin
      fails++;
      $display("FAIL scroll31_trace: %0d writes differ from the FILL trace (%0d writes)",
               trace.size(), fill_trace.size());
    end
  endtask

  task automatic test_collision;
    int c, cyc;
    logic [31:0] cd;
    cd = $urandom;
    preload(1'b1);
    start_cmd(OP_SCROLL, 1, 8'h20, 8'h07);
    c = 0;
    repeat (3) begin @(negedge clk); c++; end
    // cycle 3 is the first WR
    cpu_we = 4'b0011; cpu_sel = 1'b1; cpu_addr = 10'd5; cpu_data = cd;
    #1;
    checks++;
    if (c_en !== 1'b1 || c_we !== 4'b0011 || c_addr !== 10'd5 || c_din !== cd || t_en !== 1'b0) begin
      fails++;
      $display("FAIL collision_cpu: cen=%0b cwe=%b caddr=%0d cdin=%h ten=%0b, required 1 0011 5 %h 0",
               c_en, c_we, c_addr, c_din, t_en, cd);
    end
    @(negedge clk); c++;
    cpu_we = 4'h0;
    #1;
    checks++;
    if (t_en !== 1'b1 || t_we !== 4'hF || t_addr !== 10'd0 || t_din !== old_t[W] || c_din !== old_c[W]) begin
      fails++;
      $display("FAIL collision_delayed_wr: ten=%0b twe=%h taddr=%0d tdin=%h cdin=%h, required 1 f 0 %h %h",
               t_en, t_we, t_addr, t_din, c_din, old_t[W], old_c[W]);
    end
    wait_done(c, cyc);
    checks++;
    if (cyc != exp_cycles(OP_SCROLL, 1) + 1) begin
      fails++;
      $display("FAIL collision_cycles: got %0d required %0d", cyc, exp_cycles(OP_SCROLL, 1) + 1);
    end
    check_mem("collision", OP_SCROLL, 1, 8'h20, 8'h07);
  endtask

  task automatic test_reset_mid;
    int c, cyc;
    preload(1'b0);
    start_cmd(OP_FILL, 0, 8'hAA, 8'hBB);
    c = 0;
    while (c < 300) begin @(negedge clk); c++; end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (t_en !== 1'b0 || c_en !== 1'b0 || t_we !== 4'h0 || c_we !== 4'h0 ||
        busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: ten=%0b cen=%0b twe=%h cwe=%h busy=%0b done=%0b ready=%0b, required 0 0 0 0 0 0 1",
               t_en, c_en, t_we, c_we, busy, done, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_cmd(OP_FILL, 0, 8'h3C, 8'h5A);
    @(negedge clk);
    checks++;
    if (t_en !== 1'b1 || t_we !== 4'hF || t_addr !== 10'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart: ten=%0b twe=%h taddr=%0d busy=%0b, required 1 f 0 1",
               t_en, t_we, t_addr, busy);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != T + 1) begin
      fails++;
      $display("FAIL reset_restart_cycles: got %0d required %0d", cyc, T + 1);
    end
    check_mem("reset_restart", OP_FILL, 0, 8'h3C, 8'h5A);
  endtask

  task automatic test_back_to_back;
    int c;
    preload(1'b0);
    @(negedge clk);
    acc_cnt = 0;
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_rows = 5'd0; cmd_char = 8'h01; cmd_colour = 8'h02;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (done || c > 5000) break;
    end
    checks++;
    if (acc_cnt != 1 || !done) begin
      fails++;
      $display("FAIL b2b_single: accepts=%0d done=%0b, required 1 1", acc_cnt, done);
    end
    cmd_op = OP_SCROLL;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || acc_cnt != 1) begin
      fails++;
      $display("FAIL b2b_ready_after_done: ready=%0b accepts=%0d, required 1 1", cmd_ready, acc_cnt);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (acc_cnt != 2) begin
      fails++;
      $display("FAIL b2b_second_accept: accepts=%0d required 2", acc_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_scroll0_done: done=%0b required 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_scroll1();
    test_scroll_rand();
    test_scroll_edges();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
